// File: rtl/neighbor_table_update_pkg.sv
// neighbor_table_update_pkg: memory map, status codes, capacities and FSM states shared by the
// beacon table updater and the aggregation check.
package neighbor_table_update_pkg;
   localparam int WORD_WIDTH = 16;
   localparam int MAX_NEIGHBORS = 64;
   localparam int MAX_SINKS = 32;
   localparam int IDX_W = 7;
   localparam logic [WORD_WIDTH-1:0] AGG_FLAG = 16'h0002;
   localparam logic [WORD_WIDTH-1:0] KNOWN_SINKS_BASE = 16'h0008;
   localparam logic [WORD_WIDTH-1:0] NEIGHBOR_ID_BASE = 16'h0048;
   localparam logic [WORD_WIDTH-1:0] CLUSTER_ID_BASE = 16'h00C8;
   localparam logic [WORD_WIDTH-1:0] KNOWN_SINK_COUNT = 16'h0688;
   localparam logic [WORD_WIDTH-1:0] NEIGHBOR_COUNT = 16'h068A;
   localparam logic [1:0] STATUS_UPDATED = 2'd0;
   localparam logic [1:0] STATUS_APPENDED = 2'd1;
   localparam logic [1:0] STATUS_FULL = 2'd2;
   typedef enum logic [3:0] {
      IDLE, N_CNT, N_SCAN, N_APPEND, N_APP_CLUSTER, N_APP_COUNT,
      S_START, S_CNT, S_SCAN, S_APPEND, S_APP_COUNT, S_FIN, DONE
   } state_t;
   // Count words in memory may be corrupt or oversized; never walk past the table.
   function automatic logic [IDX_W-1:0] clamp_count(input logic [WORD_WIDTH-1:0] w,
                                                    input logic [WORD_WIDTH-1:0] max);
      return (w > max) ? max[IDX_W-1:0] : w[IDX_W-1:0];
   endfunction
   function automatic logic [WORD_WIDTH-1:0] table_addr(input logic [WORD_WIDTH-1:0] base,
                                                        input logic [IDX_W-1:0] idx);
      return base + {{(WORD_WIDTH-IDX_W-1){1'b0}}, idx, 1'b0};
   endfunction
endpackage

// File: rtl/neighbor_table_update_if.sv
// neighbor_table_update_if: single-port 16-bit word memory bus (combinational read, strobed write).
interface neighbor_table_update_if;
   import neighbor_table_update_pkg::*;
   logic [WORD_WIDTH-1:0] address;
   logic [WORD_WIDTH-1:0] data_out;
   logic [WORD_WIDTH-1:0] data_in;
   logic wr_en;
   modport master(output address, wr_en, data_out, input data_in);
   modport slave(input address, wr_en, data_out, output data_in);
endinterface

// File: rtl/neighbor_table_update_word_table_scan.sv
// word_table_scan: walks base+2i over a word table and reports key hit, last entry and next address.
module word_table_scan
   import neighbor_table_update_pkg::*;
(
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  adv,
   input  logic [WORD_WIDTH-1:0] base,
   input  logic [WORD_WIDTH-1:0] key,
   input  logic [WORD_WIDTH-1:0] data_in,
   input  logic [IDX_W-1:0]      count,
   output logic [IDX_W-1:0]      idx,
   output logic                  hit,
   output logic                  last,
   output logic [WORD_WIDTH-1:0] next_address
);
   logic [IDX_W-1:0] idx_next;
   always_ff @(posedge clock)
      if (rst || clr) idx <= '0;
      else if (adv) idx <= idx_next;
   assign idx_next = idx + 1'b1;
   assign hit = data_in == key;
   assign last = idx_next == count;
   assign next_address = table_addr(base, idx_next);
endmodule

// File: rtl/neighbor_table_update.sv
// neighbor_table_update: per-beacon dedup-scan-then-append of the neighbour, cluster and known-sink
// tables, one memory word per cycle; count words are always written last.
module neighbor_table_update
   import neighbor_table_update_pkg::*;
(
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] rx_id,
   input  logic [WORD_WIDTH-1:0] rx_cluster,
   input  logic                  rx_is_sink,
   neighbor_table_update_if.master mem,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            status,
   output logic                  sink_added
);
   state_t state, state_n;
   logic [WORD_WIDTH-1:0] id_q, cluster_q, addr_n, dout_n, next_address;
   logic [IDX_W-1:0] cnt, cnt_n, idx;
   logic [1:0] status_n;
   logic sink_q, wr_n, busy_n, done_n, sink_n, clr, adv, latch, fin, hit, last;
   word_table_scan scan (
      .clock(clock), .rst(rst), .clr(clr), .adv(adv),
      .base(state == S_SCAN ? KNOWN_SINKS_BASE : NEIGHBOR_ID_BASE),
      .key(id_q), .data_in(mem.data_in), .count(cnt),
      .idx(idx), .hit(hit), .last(last), .next_address(next_address)
   );
   always_comb begin
      state_n = state;
      addr_n = mem.address;
      dout_n = mem.data_out;
      wr_n = 1'b0;
      busy_n = busy;
      done_n = 1'b0;
      status_n = status;
      sink_n = sink_added;
      cnt_n = cnt;
      clr = 1'b0;
      adv = 1'b0;
      latch = 1'b0;
      fin = 1'b0;
      case (state)
         IDLE: if (start) begin
            latch = 1'b1;
            addr_n = NEIGHBOR_COUNT;
            busy_n = 1'b1;
            status_n = STATUS_UPDATED;
            sink_n = 1'b0;
            state_n = N_CNT;
         end
         N_CNT: begin
            cnt_n = clamp_count(mem.data_in, WORD_WIDTH'(MAX_NEIGHBORS));
            clr = 1'b1;
            addr_n = NEIGHBOR_ID_BASE;
            state_n = (cnt_n == '0) ? N_APPEND : N_SCAN;
         end
         N_SCAN: if (hit) begin
            addr_n = table_addr(CLUSTER_ID_BASE, idx);
            dout_n = cluster_q;
            wr_n = 1'b1;
            status_n = STATUS_UPDATED;
            state_n = S_START;
         end else if (last) state_n = N_APPEND;
         else begin
            adv = 1'b1;
            addr_n = next_address;
         end
         N_APPEND: if (cnt == IDX_W'(MAX_NEIGHBORS)) begin
            status_n = STATUS_FULL;
            state_n = S_START;
         end else begin
            addr_n = table_addr(NEIGHBOR_ID_BASE, cnt);
            dout_n = id_q;
            wr_n = 1'b1;
            status_n = STATUS_APPENDED;
            state_n = N_APP_CLUSTER;
         end
         N_APP_CLUSTER: begin
            addr_n = table_addr(CLUSTER_ID_BASE, cnt);
            dout_n = cluster_q;
            wr_n = 1'b1;
            state_n = N_APP_COUNT;
         end
         N_APP_COUNT: begin
            addr_n = NEIGHBOR_COUNT;
            dout_n = WORD_WIDTH'(cnt) + 1'b1;
            wr_n = 1'b1;
            state_n = S_START;
         end
         S_START: if (sink_q) begin
            addr_n = KNOWN_SINK_COUNT;
            state_n = S_CNT;
         end else fin = 1'b1;
         S_CNT: begin
            cnt_n = clamp_count(mem.data_in, WORD_WIDTH'(MAX_SINKS));
            clr = 1'b1;
            addr_n = KNOWN_SINKS_BASE;
            state_n = (cnt_n == '0) ? S_APPEND : S_SCAN;
         end
         S_SCAN: if (hit) fin = 1'b1;
         else if (last) state_n = S_APPEND;
         else begin
            adv = 1'b1;
            addr_n = next_address;
         end
         S_APPEND: if (cnt == IDX_W'(MAX_SINKS)) fin = 1'b1;
         else begin
            addr_n = table_addr(KNOWN_SINKS_BASE, cnt);
            dout_n = id_q;
            wr_n = 1'b1;
            state_n = S_APP_COUNT;
         end
         S_APP_COUNT: begin
            addr_n = KNOWN_SINK_COUNT;
            dout_n = WORD_WIDTH'(cnt) + 1'b1;
            wr_n = 1'b1;
            sink_n = 1'b1;
            state_n = S_FIN;
         end
         S_FIN: fin = 1'b1;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (fin) begin
         done_n = 1'b1;
         busy_n = 1'b0;
         state_n = DONE;
      end
   end
   always_ff @(posedge clock) begin
      if (rst) begin
         state <= IDLE;
         mem.address <= NEIGHBOR_COUNT;
         mem.wr_en <= 1'b0;
         mem.data_out <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         status <= STATUS_UPDATED;
         sink_added <= 1'b0;
         cnt <= '0;
      end else begin
         state <= state_n;
         mem.address <= addr_n;
         mem.wr_en <= wr_n;
         mem.data_out <= dout_n;
         busy <= busy_n;
         done <= done_n;
         status <= status_n;
         sink_added <= sink_n;
         cnt <= cnt_n;
      end
      if (latch) begin
         id_q <= rx_id;
         cluster_q <= rx_cluster;
         sink_q <= rx_is_sink;
      end
   end
endmodule

// File: tb/tb_neighbor_table_update.sv
// tb_neighbor_table_update: directed and random beacons against an array-based table model,
// checked by a done-driven scoreboard monitor.
module tb_neighbor_table_update;
   import neighbor_table_update_pkg::*;
   typedef struct { logic [1:0] status; bit sink; int writes; int lat; } exp_t;
   logic clock = 0, rst = 1, start = 0, rx_is_sink = 0;
   logic [15:0] rx_id = 0, rx_cluster = 0;
   logic busy, done, sink_added;
   logic [1:0] status;
   logic tb_we = 0;
   logic [9:0] tb_idx = 0;
   logic [15:0] tb_data = 0;
   logic [15:0] ram [0:1023];
   logic [15:0] ref_mem [0:1023];
   exp_t q[$];
   int checks = 0, errors = 0;
   neighbor_table_update_if bus();
   neighbor_table_update dut (
      .clock(clock), .rst(rst), .start(start), .rx_id(rx_id), .rx_cluster(rx_cluster),
      .rx_is_sink(rx_is_sink), .mem(bus), .busy(busy), .done(done), .status(status),
      .sink_added(sink_added)
   );
   always #5 clock = ~clock;
   assign bus.data_in = ram[bus.address[10:1]];
   always @(posedge clock)
      if (bus.wr_en) ram[bus.address[10:1]] <= bus.data_out;
      else if (tb_we) ram[tb_idx] <= tb_data;
   function automatic int wi(input logic [15:0] a);
      return int'(a) >> 1;
   endfunction
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // Reference: first-match search over plain arrays, then append if room.
   function automatic exp_t model(input logic [15:0] id, input logic [15:0] cl, input bit sk);
      exp_t e;
      int n, k, h;
      n = int'(ref_mem[wi(NEIGHBOR_COUNT)]);
      if (n > MAX_NEIGHBORS) n = MAX_NEIGHBORS;
      h = -1;
      for (int i = n - 1; i >= 0; i--) if (ref_mem[wi(NEIGHBOR_ID_BASE) + i] == id) h = i;
      e.sink = 0;
      e.lat = -1;
      if (h >= 0) begin
         ref_mem[wi(CLUSTER_ID_BASE) + h] = cl;
         e.status = 2'd0; e.writes = 1; e.lat = 3 + h;
      end else if (n == MAX_NEIGHBORS) begin
         e.status = 2'd2; e.writes = 0;
      end else begin
         ref_mem[wi(NEIGHBOR_ID_BASE) + n] = id;
         ref_mem[wi(CLUSTER_ID_BASE) + n] = cl;
         ref_mem[wi(NEIGHBOR_COUNT)] = 16'(n + 1);
         e.status = 2'd1; e.writes = 3; e.lat = n + 5;
      end
      if (sk) begin
         e.lat = -1;
         k = int'(ref_mem[wi(KNOWN_SINK_COUNT)]);
         if (k > MAX_SINKS) k = MAX_SINKS;
         h = -1;
         for (int j = 0; j < k; j++) if (ref_mem[wi(KNOWN_SINKS_BASE) + j] == id) h = j;
         if (h < 0 && k < MAX_SINKS) begin
            ref_mem[wi(KNOWN_SINKS_BASE) + k] = id;
            ref_mem[wi(KNOWN_SINK_COUNT)] = 16'(k + 1);
            e.sink = 1; e.writes += 2;
         end
      end
      return e;
   endfunction
   task automatic set_word(input logic [15:0] a, input logic [15:0] v);
      ref_mem[wi(a)] = v;
      tb_idx = a[10:1];
      tb_data = v;
      tb_we = 1;
      @(negedge clock);
      tb_we = 0;
   endtask
   task automatic wait_done();
      int c = 0;
      while (!done && c < 500) begin
         @(negedge clock);
         c++;
      end
      chk("done_seen", int'(done), 1);
      @(negedge clock);
   endtask
   task automatic run_txn(input logic [15:0] id, input logic [15:0] cl, input bit sk, input bit dbl);
      q.push_back(model(id, cl, sk));
      rx_id = id; rx_cluster = cl; rx_is_sink = sk; start = 1;
      @(negedge clock);
      start = 0;
      if (dbl) begin
         @(negedge clock);
         rx_id = id ^ 16'h00FF; start = 1;
         @(negedge clock);
         start = 0;
      end
      wait_done();
   endtask
   initial begin : monitor
      int cyc, t0, wcount, bad;
      logic busy_q, wr_q;
      logic [15:0] addr_q;
      exp_t e;
      cyc = 0; t0 = 0; wcount = 0; busy_q = 0; wr_q = 0; addr_q = 0;
      forever begin
         @(negedge clock);
         cyc++;
         if (busy && !busy_q) begin t0 = cyc; wcount = 0; end
         if (bus.wr_en) begin
            wcount++;
            chk("agg_flag_write", int'(bus.address == AGG_FLAG), 0);
            chk("repeat_write", int'(wr_q && addr_q == bus.address), 0);
         end
         if (done && !rst) begin
            chk("done_with_pending", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("status", int'(status), int'(e.status));
               chk("sink_added", int'(sink_added), int'(e.sink));
               chk("write_count", wcount, e.writes);
               chk("busy_at_done", int'(busy), 0);
               if (e.lat >= 0) chk("latency", cyc - t0, e.lat);
               bad = 0;
               for (int i = 0; i < 1024; i++) if (ram[i] != ref_mem[i]) bad++;
               chk("memory_words_wrong", bad, 0);
            end
         end
         busy_q = busy; wr_q = bus.wr_en; addr_q = bus.address;
      end
   end
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end
   initial begin
      int c, n, k;
      repeat (2) @(negedge clock);
      for (int i = 0; i < 1024; i++) set_word(16'(i * 2), 16'h0000);
      chk("rst_address", int'(bus.address), 16'h068A);
      chk("rst_wr_en", int'(bus.wr_en), 0);
      chk("rst_data_out", int'(bus.data_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_status", int'(status), 0);
      chk("rst_sink_added", int'(sink_added), 0);
      rst = 0;
      @(negedge clock);
      run_txn(16'd5, 16'd2, 1'b0, 1'b0);
      set_word(NEIGHBOR_COUNT, 16'd3);
      set_word(16'h0048, 16'd3); set_word(16'h004A, 16'd5); set_word(16'h004C, 16'd9);
      set_word(16'h00C8, 16'd1); set_word(16'h00CA, 16'd1); set_word(16'h00CC, 16'd1);
      run_txn(16'd5, 16'd4, 1'b0, 1'b1);
      repeat (6) @(negedge clock);
      set_word(NEIGHBOR_COUNT, 16'd64);
      for (int i = 0; i < 64; i++) set_word(16'(16'h0048 + 2 * i), 16'(100 + i));
      set_word(KNOWN_SINK_COUNT, 16'd0);
      run_txn(16'd77, 16'd9, 1'b1, 1'b0);
      set_word(NEIGHBOR_COUNT, 16'd0);
      set_word(KNOWN_SINK_COUNT, 16'd3);
      set_word(16'h0008, 16'd1); set_word(16'h000A, 16'd2); set_word(16'h000C, 16'd5);
      run_txn(16'd5, 16'd3, 1'b1, 1'b0);
      set_word(NEIGHBOR_COUNT, 16'd0);
      rx_id = 16'h0011; rx_cluster = 16'h0022; rx_is_sink = 0; start = 1;
      @(negedge clock);
      start = 0;
      c = 0;
      while (!(bus.wr_en && bus.address == CLUSTER_ID_BASE) && c < 50) begin
         @(negedge clock);
         c++;
      end
      chk("second_write_seen", int'(bus.wr_en && bus.address == CLUSTER_ID_BASE), 1);
      rst = 1;
      @(negedge clock);
      chk("rst_mid_wr_en", int'(bus.wr_en), 0);
      chk("rst_mid_busy", int'(busy), 0);
      rst = 0;
      ref_mem[wi(NEIGHBOR_ID_BASE)] = 16'h0011;
      ref_mem[wi(CLUSTER_ID_BASE)] = 16'h0022;
      repeat (8) @(negedge clock);
      chk("rst_mid_count", int'(ram[wi(NEIGHBOR_COUNT)]), 0);
      run_txn(16'h0011, 16'h0033, 1'b0, 1'b0);
      for (int t = 0; t < 40; t++) begin
         if (t % 5 == 0) begin
            c = $urandom_range(0, 9);
            n = (c == 0) ? 64 : (c == 1) ? 200 : $urandom_range(0, 10);
            set_word(NEIGHBOR_COUNT, 16'(n));
            for (int i = 0; i < (n > 64 ? 64 : n); i++)
               set_word(16'(16'h0048 + 2 * i), 16'($urandom_range(1, 12)));
            c = $urandom_range(0, 9);
            k = (c == 0) ? 32 : (c == 1) ? 40 : $urandom_range(0, 6);
            set_word(KNOWN_SINK_COUNT, 16'(k));
            for (int j = 0; j < (k > 32 ? 32 : k); j++)
               set_word(16'(16'h0008 + 2 * j), 16'($urandom_range(1, 12)));
         end
         run_txn(16'($urandom_range(1, 14)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end
      repeat (5) @(negedge clock);
      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
